// File: rtl/if_id_stage.sv
// Fetch front end: program counter, IF/ID pipeline register, load-use hazard detection,
// taken-branch flush and saturating debug event counters.
module if_id_stage #(
  parameter logic [63:0] PC_RESET  = 64'd0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_IF,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic        MemRead_IDEX,
  input  logic [4:0]  Rd_EX,
  input  logic        src_Rd_ID,
  output logic [63:0] pc_IF,
  output logic [31:0] instr_ID,
  output logic [63:0] pc_ID,
  output logic        valid_ID,
  output logic        stall,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [63:0] pc_if_q, pc_if_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic [63:0] pc_id_q, pc_id_d;
  logic        valid_id_q, valid_id_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic [4:0] rn, rm, rt;
  logic       unused_tgt_bits;

  assign rn = instr_id_q[9:5];
  assign rm = instr_id_q[20:16];
  assign rt = instr_id_q[4:0];

  // Branch targets are word aligned; the low bits are dropped rather than trusted.
  assign unused_tgt_bits = ^br_target[1:0];

  // Rm is compared even for formats without it: a spurious stall is safe, a missed one is not.
  assign stall = MemRead_IDEX && valid_id_q && (Rd_EX != 5'd31) &&
                 ((rn == Rd_EX) || (rm == Rd_EX) || (src_Rd_ID && (rt == Rd_EX)));

  always_comb begin
    pc_if_d     = pc_if_q;
    instr_id_d  = instr_id_q;
    pc_id_d     = pc_id_q;
    valid_id_d  = valid_id_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall) begin
      // Branch decision in ID uses a stale operand while stalled, so it is ignored.
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end else if (br_taken) begin
      pc_if_d    = {br_target[63:2], 2'b00};
      instr_id_d = NOP_INSTR;
      pc_id_d    = pc_if_q;
      valid_id_d = 1'b0;
      if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end else begin
      pc_if_d    = pc_if_q + 64'd4;
      instr_id_d = instr_IF;
      pc_id_d    = pc_if_q;
      valid_id_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_if_q     <= PC_RESET;
      instr_id_q  <= NOP_INSTR;
      pc_id_q     <= 64'd0;
      valid_id_q  <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      pc_if_q     <= pc_if_d;
      instr_id_q  <= instr_id_d;
      pc_id_q     <= pc_id_d;
      valid_id_q  <= valid_id_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_IF     = pc_if_q;
  assign instr_ID  = instr_id_q;
  assign pc_ID     = pc_id_q;
  assign valid_ID  = valid_id_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus queues hand-computed expected state,
// a negedge monitor pops and compares every field.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_IF;
  logic        br_taken;
  logic [63:0] br_target;
  logic        MemRead_IDEX;
  logic [4:0]  Rd_EX;
  logic        src_Rd_ID;
  logic [63:0] pc_IF;
  logic [31:0] instr_ID;
  logic [63:0] pc_ID;
  logic        valid_ID;
  logic        stall;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  localparam logic [31:0] Nop  = 32'hD503201F;
  localparam logic [31:0] Add  = 32'h8B020023; // ADD X3,X1,X2
  localparam logic [31:0] Ax31 = 32'h8B0203E3; // ADD X3,X31,X2
  localparam logic [31:0] Stur = 32'hF80000C5; // STUR X5,[X6,#0]

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] pcid;
    logic        v;
    logic        st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  if_id_stage dut (
    .clk          (clk),
    .reset        (reset),
    .instr_IF     (instr_IF),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .MemRead_IDEX (MemRead_IDEX),
    .Rd_EX        (Rd_EX),
    .src_Rd_ID    (src_Rd_ID),
    .pc_IF        (pc_IF),
    .instr_ID     (instr_ID),
    .pc_ID        (pc_ID),
    .valid_ID     (valid_ID),
    .stall        (stall),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [63:0] p);
    return 32'h1234_0000 + {16'd0, p[15:0]};
  endfunction

  function automatic void chk(input string name, input string fld,
                              input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h, expected %0h", name, fld, act, exp);
  endfunction

  task automatic push(input string name, input logic [63:0] pc, input logic [31:0] ins,
                      input logic [63:0] pcid, input logic v, input logic st,
                      input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.name = name; e.pc = pc; e.ins = ins; e.pcid = pcid;
    e.v = v; e.st = st; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a new state every cycle; compare mid-cycle when an entry is queued.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "pc_IF", pc_IF, e.pc);
      chk(e.name, "instr_ID", {32'd0, instr_ID}, {32'd0, e.ins});
      chk(e.name, "pc_ID", pc_ID, e.pcid);
      chk(e.name, "valid_ID", {63'd0, valid_ID}, {63'd0, e.v});
      chk(e.name, "stall", {63'd0, stall}, {63'd0, e.st});
      chk(e.name, "stall_cnt", {48'd0, stall_cnt}, {48'd0, e.sc});
      chk(e.name, "flush_cnt", {48'd0, flush_cnt}, {48'd0, e.fc});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; instr_IF = w(64'd0); br_taken = 1'b0; br_target = 64'd0;
    MemRead_IDEX = 1'b0; Rd_EX = 5'd0; src_Rd_ID = 1'b0;
    #2;
    push("reset", 64'd0, Nop, 64'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    step(); instr_IF = w(64'd4);
    push("idle1", 64'd4, w(64'd0), 64'd0, 1'b1, 1'b0, 16'd0, 16'd0);
    step(); instr_IF = w(64'd8);
    push("idle2", 64'd8, w(64'd4), 64'd4, 1'b1, 1'b0, 16'd0, 16'd0);
    step(); instr_IF = w(64'd12);
    push("idle3", 64'd12, w(64'd8), 64'd8, 1'b1, 1'b0, 16'd0, 16'd0);
    step(); instr_IF = Add;
    push("idle4", 64'd16, w(64'd12), 64'd12, 1'b1, 1'b0, 16'd0, 16'd0);

    step(); instr_IF = w(64'd20); MemRead_IDEX = 1'b1; Rd_EX = 5'd1;
    push("loaduse_rn", 64'd20, Add, 64'd16, 1'b1, 1'b1, 16'd0, 16'd0);
    step(); MemRead_IDEX = 1'b0;
    push("held_nomemread", 64'd20, Add, 64'd16, 1'b1, 1'b0, 16'd1, 16'd0);
    step(); instr_IF = Ax31;
    push("resume", 64'd24, w(64'd20), 64'd20, 1'b1, 1'b0, 16'd1, 16'd0);
    step(); instr_IF = Stur; MemRead_IDEX = 1'b1; Rd_EX = 5'd31;
    push("rd31", 64'd28, Ax31, 64'd24, 1'b1, 1'b0, 16'd1, 16'd0);
    step(); instr_IF = w(64'd32); Rd_EX = 5'd5; src_Rd_ID = 1'b1;
    push("stur_rt", 64'd32, Stur, 64'd28, 1'b1, 1'b1, 16'd1, 16'd0);
    step(); src_Rd_ID = 1'b0;
    push("stur_no_src", 64'd32, Stur, 64'd28, 1'b1, 1'b0, 16'd2, 16'd0);
    step(); instr_IF = w(64'd36); MemRead_IDEX = 1'b0; br_taken = 1'b1; br_target = 64'h103;
    push("branch_req", 64'd36, w(64'd32), 64'd32, 1'b1, 1'b0, 16'd2, 16'd0);
    step(); br_taken = 1'b0; instr_IF = Add; MemRead_IDEX = 1'b1; Rd_EX = 5'd3;
    push("flushed_novalid", 64'h100, Nop, 64'd36, 1'b0, 1'b0, 16'd2, 16'd1);
    step(); instr_IF = w(64'h104); Rd_EX = 5'd2; br_taken = 1'b1; br_target = 64'h200;
    push("stall_and_br", 64'h104, Add, 64'h100, 1'b1, 1'b1, 16'd2, 16'd1);
    step(); MemRead_IDEX = 1'b0;
    push("br_after_stall", 64'h104, Add, 64'h100, 1'b1, 1'b0, 16'd3, 16'd1);
    step(); br_taken = 1'b0; instr_IF = Add;
    push("redirect", 64'h200, Nop, 64'h104, 1'b0, 1'b0, 16'd3, 16'd2);
    step(); MemRead_IDEX = 1'b1; Rd_EX = 5'd1;
    push("long_stall_start", 64'h204, Add, 64'h200, 1'b1, 1'b1, 16'd3, 16'd2);

    for (int i = 1; i <= 70000; i++) begin
      @(posedge clk);
      if (i == 65531) begin
        #1 push("cnt_below_sat", 64'h204, Add, 64'h200, 1'b1, 1'b1, 16'hFFFE, 16'd2);
      end
    end
    #1 push("cnt_saturated", 64'h204, Add, 64'h200, 1'b1, 1'b1, 16'hFFFF, 16'd2);
    @(negedge clk);

    @(posedge clk);
    #2 reset = 1'b0;
    push("async_reset", 64'd0, Nop, 64'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    #2 reset = 1'b1; MemRead_IDEX = 1'b0; instr_IF = w(64'd0);
    step();
    push("first_after_reset", 64'd4, w(64'd0), 64'd0, 1'b1, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
